// File: rtl/reg_file.sv
// 32x32 register file: two registered read ports, one write port, entry 0 reads as zero.
// After every reset a clear sequencer zeroes all entries before ready rises.
module reg_file #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_a,
   output logic [WIDTH-1:0]  rdata_b,
   output logic              ready
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic [WIDTH-1:0]   rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0]   rdata_b_q, rdata_b_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];

   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [WIDTH-1:0]   mem_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   // The clear sequencer and the user write port share the single array write port.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      rdata_a_d = '0;
      rdata_b_d = '0;
      mem_we    = 1'b0;
      mem_addr  = waddr;
      mem_wdata = wdata;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ENTRY) begin
               state_d = RUN;
            end
         end
         RUN: begin
            mem_we = we && (waddr != '0);
            if (raddr_a == '0) begin
               rdata_a_d = '0;
            end else if (we && (waddr == raddr_a)) begin
               rdata_a_d = wdata;
            end else begin
               rdata_a_d = mem_q[raddr_a];
            end
            if (raddr_b == '0) begin
               rdata_b_d = '0;
            end else if (we && (waddr == raddr_b)) begin
               rdata_b_d = wdata;
            end else begin
               rdata_b_d = mem_q[raddr_b];
            end
         end
      endcase
   end

   // Reset takes priority, so nothing lands in the array while rst_n is low.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;
   assign ready   = (state_q == RUN);

endmodule
